// File: rtl/alu_pkg.sv
// ALUOp encodings, arbiter FSM states and the legal-op check shared by the
// ALU sharing arbiter (legality only matters when ALU_ARB_OPCHECK_EN is defined).
package alu_pkg;

  localparam logic [4:0] OP_SLL  = 5'b00000;
  localparam logic [4:0] OP_SRA  = 5'b00001;
  localparam logic [4:0] OP_SRL  = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_XOR  = 5'b00111;
  localparam logic [4:0] OP_NOR  = 5'b01000;
  localparam logic [4:0] OP_SLTU = 5'b01001;
  localparam logic [4:0] OP_SLT  = 5'b01010;
  localparam logic [4:0] OP_MUL  = 5'b01101;
  localparam logic [4:0] OP_BNE  = 5'b01111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // The contiguous block SLL..SLT plus the two stragglers MUL and BNE
  function automatic logic op_is_legal(input logic [4:0] op);
    return (op <= OP_SLT) || (op == OP_MUL) || (op == OP_BNE);
  endfunction

endpackage

// File: rtl/alu_share_arbiter_rr_arb2.sv
// Combinational two-way round-robin picker: a lone requester always wins,
// on a tie the requester that was not granted last time wins.
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_grant ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one external combinational ALU between two requesters (IDLE->EXEC->RESP).
// Define ALU_ARB_OPCHECK_EN to reject illegal ALUOps with resp_err instead of using the ALU default.
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int OP_W   = 5,
  parameter int SA_W   = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          req_valid,
  output logic [1:0]          req_ready,
  input  logic [2*DATA_W-1:0] req_a,
  input  logic [2*DATA_W-1:0] req_b,
  input  logic [2*SA_W-1:0]   req_sa,
  input  logic [2*OP_W-1:0]   req_op,
  output logic [1:0]          resp_valid,
  input  logic [1:0]          resp_ready,
  output logic [DATA_W-1:0]   resp_result,
  output logic                resp_zero,
  output logic                resp_err,
  output logic [DATA_W-1:0]   alu_a,
  output logic [DATA_W-1:0]   alu_b,
  output logic [SA_W-1:0]     alu_sa,
  output logic [OP_W-1:0]     alu_op,
  input  logic [DATA_W-1:0]   alu_result,
  input  logic                alu_zero,
  output logic                busy
);

  state_t            state;
  logic              last_grant;
  logic              resp_id;
  logic [1:0]        grant;
  logic              accept;
  logic              acc_id;
  logic [DATA_W-1:0] sel_a;
  logic [DATA_W-1:0] sel_b;
  logic [SA_W-1:0]   sel_sa;
  logic [OP_W-1:0]   sel_op;

  rr_arb2 u_rr_arb2 (
    .valid      (req_valid),
    .last_grant (last_grant),
    .grant      (grant)
  );

  assign req_ready = (state == ST_IDLE) ? grant : 2'b00;
  assign accept    = |(req_valid & req_ready);
  assign acc_id    = req_ready[1];

  assign sel_a  = acc_id ? req_a[2*DATA_W-1:DATA_W] : req_a[DATA_W-1:0];
  assign sel_b  = acc_id ? req_b[2*DATA_W-1:DATA_W] : req_b[DATA_W-1:0];
  assign sel_sa = acc_id ? req_sa[2*SA_W-1:SA_W]    : req_sa[SA_W-1:0];
  assign sel_op = acc_id ? req_op[2*OP_W-1:OP_W]    : req_op[OP_W-1:0];

`ifdef ALU_ARB_OPCHECK_EN
  logic op_bad;
  logic err_q;

  // The illegal flag rides alongside the operands so EXEC can squash the ALU output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_bad <= 1'b0;
      err_q  <= 1'b0;
    end else if (state == ST_IDLE && accept) begin
      op_bad <= !op_is_legal(sel_op);
    end else if (state == ST_EXEC) begin
      err_q  <= op_bad;
    end
  end

  assign resp_err = err_q;
`else
  assign resp_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      last_grant  <= 1'b1;
      resp_id     <= 1'b0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_sa      <= '0;
      alu_op      <= '0;
      resp_result <= '0;
      resp_zero   <= 1'b0;
      resp_valid  <= 2'b00;
      busy        <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            alu_a      <= sel_a;
            alu_b      <= sel_b;
            alu_sa     <= sel_sa;
`ifdef ALU_ARB_OPCHECK_EN
            alu_op     <= op_is_legal(sel_op) ? sel_op : '0;
`else
            alu_op     <= sel_op;
`endif
            resp_id    <= acc_id;
            last_grant <= acc_id;
            busy       <= 1'b1;
            state      <= ST_EXEC;
          end
        end
        ST_EXEC: begin
`ifdef ALU_ARB_OPCHECK_EN
          resp_result <= op_bad ? '0 : alu_result;
          resp_zero   <= op_bad ? 1'b0 : alu_zero;
`else
          resp_result <= alu_result;
          resp_zero   <= alu_zero;
`endif
          resp_valid  <= resp_id ? 2'b10 : 2'b01;
          state       <= ST_RESP;
        end
        ST_RESP: begin
          // Only the owner's ready completes the response
          if (resp_ready[resp_id]) begin
            resp_valid <= 2'b00;
            busy       <= 1'b0;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter with a behavioural ALU model;
// the illegal-op expectations follow ALU_ARB_OPCHECK_EN.
module tb_alu_share_arbiter;
  import alu_pkg::*;

  localparam int DATA_W = 32;
  localparam int OP_W   = 5;
  localparam int SA_W   = 5;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [1:0]          req_valid;
  logic [1:0]          req_ready;
  logic [2*DATA_W-1:0] req_a;
  logic [2*DATA_W-1:0] req_b;
  logic [2*SA_W-1:0]   req_sa;
  logic [2*OP_W-1:0]   req_op;
  logic [1:0]          resp_valid;
  logic [1:0]          resp_ready;
  logic [DATA_W-1:0]   resp_result;
  logic                resp_zero;
  logic                resp_err;
  logic [DATA_W-1:0]   alu_a;
  logic [DATA_W-1:0]   alu_b;
  logic [SA_W-1:0]     alu_sa;
  logic [OP_W-1:0]     alu_op;
  logic [DATA_W-1:0]   alu_result;
  logic                alu_zero;
  logic                busy;

  typedef struct {
    logic [DATA_W-1:0] result;
    logic              zero;
    logic              err;
  } exp_t;

  exp_t exp_q0[$];
  exp_t exp_q1[$];
  int   grant_log[$];
  int   checks = 0;
  int   errors = 0;
  int   cycle = 0;
  int   accept_edge = 0;
  logic seen = 1'b0;

  alu_share_arbiter #(.DATA_W(DATA_W), .OP_W(OP_W), .SA_W(SA_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_sa      (req_sa),
    .req_op      (req_op),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_result (resp_result),
    .resp_zero   (resp_zero),
    .resp_err    (resp_err),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_sa      (alu_sa),
    .alu_op      (alu_op),
    .alu_result  (alu_result),
    .alu_zero    (alu_zero),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle++;

  // Stand-in for the CPU's combinational ALU, bne inverts the zero flag
  always_comb begin
    alu_result = '0;
    case (alu_op)
      OP_SLL:  alu_result = alu_b << alu_sa;
      OP_SRA:  alu_result = $signed(alu_b) >>> alu_sa;
      OP_SRL:  alu_result = alu_b >> alu_sa;
      OP_ADD:  alu_result = alu_a + alu_b;
      OP_SUB:  alu_result = alu_a - alu_b;
      OP_AND:  alu_result = alu_a & alu_b;
      OP_OR:   alu_result = alu_a | alu_b;
      OP_XOR:  alu_result = alu_a ^ alu_b;
      OP_NOR:  alu_result = ~(alu_a | alu_b);
      OP_SLTU: alu_result = {{(DATA_W-1){1'b0}}, alu_a < alu_b};
      OP_SLT:  alu_result = {{(DATA_W-1){1'b0}}, $signed(alu_a) < $signed(alu_b)};
      OP_MUL:  alu_result = alu_a * alu_b;
      OP_BNE:  alu_result = alu_a - alu_b;
      default: alu_result = '0;
    endcase
    alu_zero = (alu_op == OP_BNE) ? (alu_result != '0) : (alu_result == '0);
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic report_timeout(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: timed out waiting for DUT", name);
  endtask

  // Drives one requester and queues the responses it should eventually see
  task automatic applyStimulus(input int id, input logic [OP_W-1:0] op, input logic [DATA_W-1:0] a,
                               input logic [DATA_W-1:0] b, input logic [SA_W-1:0] sa,
                               input logic [DATA_W-1:0] res, input logic zero, input logic err,
                               input int n_exp);
    exp_t e;
    req_a[id*DATA_W +: DATA_W] = a;
    req_b[id*DATA_W +: DATA_W] = b;
    req_sa[id*SA_W +: SA_W]    = sa;
    req_op[id*OP_W +: OP_W]    = op;
    req_valid[id]              = 1'b1;
    e.result = res;
    e.zero   = zero;
    e.err    = err;
    for (int k = 0; k < n_exp; k++) begin
      if (id == 0) exp_q0.push_back(e);
      else         exp_q1.push_back(e);
    end
  endtask

  task automatic wait_accepts(input int n);
    int  target;
    bit  done;
    target = grant_log.size() + n;
    done   = 0;
    for (int k = 0; k < 200 && !done; k++) begin
      @(posedge clk);
      #1;
      if (grant_log.size() >= target) done = 1;
    end
    req_valid = 2'b00;
    if (!done) report_timeout("accept");
  endtask

  task automatic wait_drain();
    bit done;
    done = 0;
    for (int k = 0; k < 200 && !done; k++) begin
      @(posedge clk);
      #2;
      if (exp_q0.size() == 0 && exp_q1.size() == 0 && resp_valid == 2'b00 && !busy) done = 1;
    end
    if (!done) report_timeout("drain");
  endtask

  // Accept observer: logs who was granted and when
  always @(negedge clk) begin
    if (rst_n && req_ready != 2'b00) begin
      checkOutput("req_ready_onehot", {63'b0, $onehot(req_ready)}, 64'd1);
      for (int i = 0; i < 2; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          grant_log.push_back(i);
          accept_edge = cycle + 1;
        end
      end
    end
  end

  // Response monitor: latency on first sight, scoreboard compare on handshake
  always @(negedge clk) begin
    exp_t e;
    int   id;
    if (!rst_n) begin
      seen = 1'b0;
    end else if (resp_valid != 2'b00) begin
      checkOutput("resp_valid_onehot", {63'b0, $onehot(resp_valid)}, 64'd1);
      id = resp_valid[1] ? 1 : 0;
      if (!seen) begin
        seen = 1'b1;
        checkOutput("latency", 64'(cycle + 1 - accept_edge), 64'd2);
      end
      if (resp_ready[id]) begin
        seen = 1'b0;
        if ((id == 0 && exp_q0.size() == 0) || (id == 1 && exp_q1.size() == 0)) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_response: got response for requester %0d, expected none", id);
        end else begin
          e = (id == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
          checkOutput($sformatf("result_req%0d", id), 64'(resp_result), 64'(e.result));
          checkOutput($sformatf("zero_req%0d", id), 64'(resp_zero), 64'(e.zero));
          checkOutput($sformatf("err_req%0d", id), 64'(resp_err), 64'(e.err));
        end
      end
    end
  end

  initial begin
    int  base;
    bit  got;
    req_valid  = 2'b00;
    req_a      = '0;
    req_b      = '0;
    req_sa     = '0;
    req_op     = '0;
    resp_ready = 2'b11;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_resp_valid", 64'(resp_valid), 64'd0);
    checkOutput("rst_alu_a", 64'(alu_a), 64'd0);
    checkOutput("rst_alu_op", 64'(alu_op), 64'd0);
    checkOutput("rst_resp_result", 64'(resp_result), 64'd0);
    checkOutput("rst_resp_zero", 64'(resp_zero), 64'd0);
    checkOutput("rst_resp_err", 64'(resp_err), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] single add on requester 0");
    @(posedge clk); #1;
    applyStimulus(0, OP_ADD, 32'd5, 32'd7, 5'd0, 32'd12, 1'b0, 1'b0, 1);
    #1;
    checkOutput("single_req_ready", 64'(req_ready), 64'd1);
    wait_accepts(1);
    wait_drain();
    checkOutput("alu_a_retained", 64'(alu_a), 64'd5);

    $display("[TB] simultaneous requests after reset");
    @(negedge clk); rst_n = 1'b0;
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    base = grant_log.size();
    applyStimulus(0, OP_SUB, 32'd3, 32'd1, 5'd0, 32'd2, 1'b0, 1'b0, 1);
    applyStimulus(1, OP_AND, 32'd2, 32'd2, 5'd0, 32'd2, 1'b0, 1'b0, 1);
    wait_accepts(2);
    wait_drain();
    checkOutput("simul_first", 64'(grant_log[base]), 64'd0);
    checkOutput("simul_second", 64'(grant_log[base+1]), 64'd1);

    $display("[TB] fairness with both requesters held valid");
    base = grant_log.size();
    applyStimulus(0, OP_ADD, 32'd1, 32'd1, 5'd0, 32'd2, 1'b0, 1'b0, 2);
    applyStimulus(1, OP_XOR, 32'd6, 32'd3, 5'd0, 32'd5, 1'b0, 1'b0, 2);
    wait_accepts(4);
    wait_drain();
    for (int k = 0; k < 4; k++)
      checkOutput($sformatf("fair_grant%0d", k), 64'(grant_log[base+k]), 64'(k % 2));

    $display("[TB] bne, shift and signed compare");
    applyStimulus(1, OP_BNE, 32'd9, 32'd9, 5'd0, 32'd0, 1'b0, 1'b0, 1);
    wait_accepts(1);
    wait_drain();
    applyStimulus(0, OP_SLL, 32'd0, 32'd1, 5'd4, 32'd16, 1'b0, 1'b0, 1);
    wait_accepts(1);
    wait_drain();
    applyStimulus(0, OP_SLT, 32'hFFFF_FFFF, 32'd1, 5'd0, 32'd1, 1'b0, 1'b0, 1);
    wait_accepts(1);
    wait_drain();

    $display("[TB] response backpressure");
    resp_ready = 2'b01;
    applyStimulus(1, OP_ADD, 32'd10, 32'd20, 5'd0, 32'd30, 1'b0, 1'b0, 1);
    wait_accepts(1);
    applyStimulus(0, OP_ADD, 32'd1, 32'd1, 5'd0, 32'd2, 1'b0, 1'b0, 1);
    got = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (resp_valid[1]) got = 1;
    end
    if (!got) report_timeout("bp_resp_valid");
    repeat (5) begin
      @(negedge clk);
      checkOutput("bp_resp_valid_held", 64'(resp_valid), 64'd2);
      checkOutput("bp_req_ready_low", 64'(req_ready), 64'd0);
    end
    @(posedge clk); #1;
    resp_ready = 2'b11;
    @(posedge clk); #2;
    checkOutput("bp_completed", 64'(resp_valid), 64'd0);
    checkOutput("bp_req0_ready", 64'(req_ready), 64'd1);
    wait_accepts(1);
    wait_drain();

    $display("[TB] illegal opcode");
`ifdef ALU_ARB_OPCHECK_EN
    applyStimulus(0, 5'b01011, 32'd7, 32'd3, 5'd0, 32'd0, 1'b0, 1'b1, 1);
    wait_accepts(1);
    checkOutput("illegal_alu_op", 64'(alu_op), 64'd0);
`else
    applyStimulus(0, 5'b01011, 32'd7, 32'd3, 5'd0, 32'd0, 1'b1, 1'b0, 1);
    wait_accepts(1);
    checkOutput("illegal_alu_op", 64'(alu_op), 64'b01011);
`endif
    wait_drain();

    $display("[TB] reset during EXEC");
    applyStimulus(0, OP_ADD, 32'd4, 32'd4, 5'd0, 32'd8, 1'b0, 1'b0, 0);
    wait_accepts(1);
    checkOutput("exec_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_busy", 64'(busy), 64'd0);
    checkOutput("abort_alu_a", 64'(alu_a), 64'd0);
    checkOutput("abort_alu_op", 64'(alu_op), 64'd0);
    checkOutput("abort_resp_valid", 64'(resp_valid), 64'd0);
    checkOutput("abort_resp_result", 64'(resp_result), 64'd0);
    #1 rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      checkOutput("abort_no_resp", 64'(resp_valid), 64'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
